// File: rtl/divmod_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and one divmod unit.
// slave: arbiter side (requester req/a/b in, results out, divmod go/rst/a/b out);
// master: environment side (requesters and the divmod instance).
interface divmod_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             done0;
    logic [WIDTH-1:0] div0;
    logic [WIDTH-1:0] mod0;
    logic             err0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             done1;
    logic [WIDTH-1:0] div1;
    logic [WIDTH-1:0] mod1;
    logic             err1;
    logic             timeout;
    logic             busy;
    logic             dm_go;
    logic             dm_rst;
    logic [WIDTH-1:0] dm_a;
    logic [WIDTH-1:0] dm_b;
    logic             dm_ready;
    logic             dm_error;
    logic [WIDTH-1:0] dm_div;
    logic [WIDTH-1:0] dm_mod;

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        input  dm_ready, dm_error, dm_div, dm_mod,
        output done0, div0, mod0, err0,
        output done1, div1, mod1, err1,
        output timeout, busy,
        output dm_go, dm_rst, dm_a, dm_b
    );

    modport master (
        output req0, a0, b0, req1, a1, b1,
        output dm_ready, dm_error, dm_div, dm_mod,
        input  done0, div0, mod0, err0,
        input  done1, div1, mod1, err1,
        input  timeout, busy,
        input  dm_go, dm_rst, dm_a, dm_b
    );
endinterface

// File: rtl/divmod_arbiter.sv
// Round-robin scheduler sharing one divmod unit between two requesters.
// Ports: clk, rst (sync, active-high), bus (divmod_arbiter_if.slave).
module divmod_arbiter #(
    parameter int WIDTH_LOG = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic           clk,
    input  logic           rst,
    divmod_arbiter_if.slave bus
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q;
    logic             owner_q;
    logic             last_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             go_q;
    logic             abort_q;
    logic             done0_q;
    logic             done1_q;
    logic [WIDTH-1:0] div0_q;
    logic [WIDTH-1:0] mod0_q;
    logic             err0_q;
    logic [WIDTH-1:0] div1_q;
    logic [WIDTH-1:0] mod1_q;
    logic             err1_q;
    logic             tout_q;
    logic [CW-1:0]    cnt_q;

    logic             grant_v;
    logic             grant_id;
    logic [CW-1:0]    cnt_inc;
    logic             fin;
    logic             f_err;
    logic             f_tout;
    logic [WIDTH-1:0] f_div;
    logic [WIDTH-1:0] f_mod;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_v  = bus.req0 | bus.req1;
        grant_id = bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_id = ~last_q;
        end
    end

    // Completion of the WAIT state: either divmod answered or the
    // watchdog expired; the answer wins if both happen together.
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        fin     = 1'b0;
        f_err   = 1'b0;
        f_tout  = 1'b0;
        f_div   = '0;
        f_mod   = '0;
        if (state_q == WAIT) begin
            if (bus.dm_ready) begin
                fin = 1'b1;
                if (bus.dm_error) begin
                    f_err = 1'b1;
                end else begin
                    f_div = bus.dm_div;
                    f_mod = bus.dm_mod;
                end
            end else if (TIMEOUT != 0 && cnt_inc == TMAX) begin
                fin    = 1'b1;
                f_err  = 1'b1;
                f_tout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            go_q    <= 1'b0;
            abort_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            div0_q  <= '0;
            mod0_q  <= '0;
            err0_q  <= 1'b0;
            div1_q  <= '0;
            mod1_q  <= '0;
            err1_q  <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            go_q    <= 1'b0;
            abort_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_v) begin
                        owner_q <= grant_id;
                        last_q  <= grant_id;
                        a_q     <= grant_id ? bus.a1 : bus.a0;
                        b_q     <= grant_id ? bus.b1 : bus.b0;
                        go_q    <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (fin) begin
                        if (owner_q) begin
                            div1_q  <= f_div;
                            mod1_q  <= f_mod;
                            err1_q  <= f_err;
                            done1_q <= 1'b1;
                        end else begin
                            div0_q  <= f_div;
                            mod0_q  <= f_mod;
                            err0_q  <= f_err;
                            done0_q <= 1'b1;
                        end
                        tout_q  <= f_tout;
                        abort_q <= f_tout;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done0   = done0_q;
    assign bus.div0    = div0_q;
    assign bus.mod0    = mod0_q;
    assign bus.err0    = err0_q;
    assign bus.done1   = done1_q;
    assign bus.div1    = div1_q;
    assign bus.mod1    = mod1_q;
    assign bus.err1    = err1_q;
    assign bus.timeout = tout_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.dm_go   = go_q;
    assign bus.dm_rst  = rst | abort_q;
    assign bus.dm_a    = a_q;
    assign bus.dm_b    = b_q;
endmodule

// File: tb/tb_divmod_arbiter.sv
// Directed bench for divmod_arbiter with a behavioural divmod stub.
// Stub: ready drops after go, returns LAT cycles later; b=0 errors at once.
module tb_divmod_arbiter;
    localparam int WL  = 4;
    localparam int W   = 16;
    localparam int TO  = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divmod_arbiter_if #(.WIDTH(W)) bus ();

    divmod_arbiter #(
        .WIDTH_LOG(WL),
        .TIMEOUT  (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic         stall;
    int           scnt;
    logic [W-1:0] sa;
    logic [W-1:0] sb;

    always @(posedge clk) begin
        if (bus.dm_rst) begin
            bus.dm_ready <= 1'b1;
            bus.dm_error <= 1'b0;
            bus.dm_div   <= '0;
            bus.dm_mod   <= '0;
            scnt         <= 0;
        end else if (bus.dm_go) begin
            if (bus.dm_b == '0) begin
                bus.dm_ready <= 1'b1;
                bus.dm_error <= 1'b1;
                bus.dm_div   <= '0;
                bus.dm_mod   <= '0;
            end else begin
                bus.dm_ready <= 1'b0;
                bus.dm_error <= 1'b0;
                sa           <= bus.dm_a;
                sb           <= bus.dm_b;
                scnt         <= LAT;
            end
        end else if (!bus.dm_ready && !stall) begin
            if (scnt <= 1) begin
                bus.dm_ready <= 1'b1;
                bus.dm_div   <= sa / sb;
                bus.dm_mod   <= sa % sb;
            end else begin
                scnt <= scnt - 1;
            end
        end
    end

    int   done0_n = 0;
    int   done1_n = 0;
    int   go_n    = 0;
    int   long_n  = 0;
    int   dmr_n   = 0;
    logic pd0     = 1'b0;
    logic pd1     = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done0) done0_n <= done0_n + 1;
            if (bus.done1) done1_n <= done1_n + 1;
            if (bus.dm_go) go_n <= go_n + 1;
            if (bus.dm_rst) dmr_n <= dmr_n + 1;
            if ((bus.done0 && pd0) || (bus.done1 && pd1)) long_n <= long_n + 1;
        end
        pd0 <= bus.done0;
        pd1 <= bus.done1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_one(input bit id, input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           output int lat, output int go_at);
        @(negedge clk);
        if (id) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b;
        end
        lat   = -1;
        go_at = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.dm_go && go_at < 0) go_at = n;
            if (id ? bus.done1 : bus.done0) begin
                lat = n;
                break;
            end
        end
        if (id) bus.req1 = 1'b0;
        else    bus.req0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int lat;
    int go_at;
    int base;
    int base2;
    int order[$];

    initial begin
        rst      = 1'b1;
        stall    = 1'b0;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;

        repeat (2) @(negedge clk);
        check("rst_dm_rst", 32'(bus.dm_rst), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", {bus.done0, bus.done1}, 0);
        check("rst_res0", {bus.div0, bus.mod0}, 0);
        check("rst_res1", {bus.div1, bus.mod1}, 0);
        check("rst_err_to", {bus.err0, bus.err1, bus.timeout}, 0);
        check("rst_go", 32'(bus.dm_go), 0);
        check("rst_dm_ab", {bus.dm_a, bus.dm_b}, 0);
        rst = 1'b0;

        // single transfer 100/7
        base = done1_n;
        run_one(0, 16'd100, 16'd7, lat, go_at);
        check("t1_go_cycle", 32'(go_at), 1);
        check("t1_latency", 32'(lat), 32'(LAT + 3));
        check("t1_div0", 32'(bus.div0), 14);
        check("t1_mod0", 32'(bus.mod0), 2);
        check("t1_err0", 32'(bus.err0), 0);
        @(negedge clk);
        check("t1_done0_off", 32'(bus.done0), 0);
        check("t1_done1_none", 32'(done1_n - base), 0);

        // simultaneous requests right after reset: requester 0 first
        do_reset();
        base = go_n;
        order.delete();
        @(negedge clk);
        bus.req0 = 1'b1; bus.a0 = 16'd10; bus.b0 = 16'd3;
        bus.req1 = 1'b1; bus.a1 = 16'd20; bus.b1 = 16'd6;
        for (int n = 0; n < 100 && order.size() < 2; n++) begin
            @(negedge clk);
            if (bus.done0) begin order.push_back(0); bus.req0 = 1'b0; end
            if (bus.done1) begin order.push_back(1); bus.req1 = 1'b0; end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        #1;
        check("t2_count", 32'(order.size()), 2);
        check("t2_first", (order.size() > 0) ? 32'(order[0]) : 32'hFF, 0);
        check("t2_div0", 32'(bus.div0), 3);
        check("t2_mod0", 32'(bus.mod0), 1);
        check("t2_div1", 32'(bus.div1), 3);
        check("t2_mod1", 32'(bus.mod1), 2);
        check("t2_go_pulses", 32'(go_n - base), 2);

        // divide by zero on requester 1, then a normal one
        run_one(1, 16'd55, 16'd0, lat, go_at);
        check("t3_latency", 32'(lat), 3);
        check("t3_err1", 32'(bus.err1), 1);
        check("t3_res1", {bus.div1, bus.mod1}, 0);
        check("t3_timeout", 32'(bus.timeout), 0);
        run_one(1, 16'd9, 16'd2, lat, go_at);
        check("t3b_div1", 32'(bus.div1), 4);
        check("t3b_mod1", 32'(bus.mod1), 1);
        check("t3b_err1", 32'(bus.err1), 0);

        // fairness with both requesters held high
        base = long_n;
        order.delete();
        @(negedge clk);
        bus.req0 = 1'b1; bus.a0 = 16'd10; bus.b0 = 16'd3;
        bus.req1 = 1'b1; bus.a1 = 16'd20; bus.b1 = 16'd6;
        for (int n = 0; n < 300 && order.size() < 6; n++) begin
            @(negedge clk);
            if (bus.done0) order.push_back(0);
            if (bus.done1) order.push_back(1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("t4_count", 32'(order.size()), 6);
        foreach (order[i]) check($sformatf("t4_grant%0d", i),
                                 32'(order[i]), 32'(i % 2));
        @(negedge clk);
        #1;
        check("t4_long_pulse", 32'(long_n - base), 0);

        // watchdog abort
        stall = 1'b1;
        base  = dmr_n;
        run_one(0, 16'd50, 16'd5, lat, go_at);
        check("t5_latency", 32'(lat), 32'(TO + 2));
        check("t5_dm_rst", 32'(bus.dm_rst), 1);
        check("t5_err0", 32'(bus.err0), 1);
        check("t5_res0", {bus.div0, bus.mod0}, 0);
        check("t5_timeout", 32'(bus.timeout), 1);
        @(negedge clk);
        #1;
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_dm_rst_len", 32'(dmr_n - base), 1);
        stall = 1'b0;

        // reset in the middle of a long division
        stall = 1'b1;
        @(negedge clk);
        base  = done0_n;
        base2 = done1_n;
        bus.req0 = 1'b1; bus.a0 = 16'd65535; bus.b0 = 16'd1;
        repeat (4) @(negedge clk);
        check("t6_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_dm_rst", 32'(bus.dm_rst), 1);
        bus.req0 = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        #1;
        check("t6_res", {bus.div0, bus.mod0, bus.div1, bus.mod1}, 0);
        check("t6_err_to", {bus.err0, bus.err1, bus.timeout}, 0);
        check("t6_no_done", 32'(done0_n - base + done1_n - base2), 0);
        run_one(0, 16'd81, 16'd9, lat, go_at);
        check("t6b_latency", 32'(lat), 32'(LAT + 3));
        check("t6b_div0", 32'(bus.div0), 9);
        check("t6b_mod0", 32'(bus.mod0), 0);
        check("t6b_err0", 32'(bus.err0), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/divmod_arbiter.md
Name: divmod_arbiter

Overview:
- Round-robin scheduler that shares one divmod unit between two requesters.
- Each requester gets a req/done handshake with private, registered result registers.
- The block sequences the divider's go/ready protocol and drives its rst, including abort on timeout.
- Sits between the prime-search control blocks and a single divmod instance.

Parameters:
- WIDTH_LOG, 4, operand width is 1 << WIDTH_LOG (WIDTH); must match the attached divmod.
- TIMEOUT, 255, maximum WAIT cycles before abort; 0 disables the watchdog.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 request; held high with a0/b0 stable until done0
- a0  input  WIDTH  requester 0 dividend
- b0  input  WIDTH  requester 0 divisor
- done0  output  1  one-cycle pulse: requester 0 results valid
- div0  output  WIDTH  requester 0 quotient, held until the next done0
- mod0  output  WIDTH  requester 0 remainder, held until the next done0
- err0  output  1  requester 0 error (divide-by-zero or timeout), held until the next done0
- req1, a1, b1, done1, div1, mod1, err1  same as the requester 0 ports, for requester 1
- timeout  output  1  last completion (either requester) was a watchdog abort; held until the next done
- busy  output  1  high in every state except IDLE
- dm_go  output  1  divmod go
- dm_rst  output  1  divmod reset = rst OR abort pulse
- dm_a  output  WIDTH  divmod dividend
- dm_b  output  WIDTH  divmod divisor
- dm_ready  input  1  divmod ready (registered inside divmod)
- dm_error  input  1  divmod error
- dm_div  input  WIDTH  divmod quotient
- dm_mod  input  WIDTH  divmod remainder

Behaviour:
- Reset values: state=IDLE; done0=done1=0; div*/mod*=0; err*=0; timeout=0; dm_go=0; dm_a=dm_b=0; last_grant=1 (requester 0 wins the first tie); wait counter=0. dm_rst=1 while rst is high.
- States: IDLE, ISSUE, WAIT, DONE. busy=0 only in IDLE.
- IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On grant: latch owner, last_grant<=owner, dm_a/dm_b<=owner operands; go to ISSUE.
- ISSUE: dm_go=1 for exactly this cycle with the latched operands. Clear the wait counter. Go to WAIT.
- WAIT:
  - Each cycle, if dm_ready=1: capture into the owner's registers.
    - If dm_error=1: div=0, mod=0, err=1.
    - Otherwise: div=dm_div, mod=dm_mod, err=0.
    - timeout<=0; go to DONE.
  - Otherwise increment the wait counter. If TIMEOUT!=0 and the counter reaches TIMEOUT:
    - assert dm_rst for 1 cycle;
    - owner gets div=0, mod=0, err=1; timeout<=1;
    - go to DONE.
  - dm_ready is never sampled in ISSUE. The first WAIT cycle is the first cycle in which divmod's registered ready reflects the go.
- DONE:
  - done_owner=1 for this single cycle; the other done stays 0.
  - req inputs are ignored; go to IDLE.
  - A requester must drop req before the next edge unless it issues a new request. If req is still high in IDLE, it is a new request.
- Latency: request seen in IDLE at cycle 0; dm_go at cycle 1; result captured at the first cycle k≥2 with dm_ready=1; done pulses at cycle k+1.
  - Divide-by-zero: done at cycle 3.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Operand latching: a*/b* may change after ISSUE without effect, though requesters keep them stable per the handshake.
- Reset mid-operation:
  - Any state returns to IDLE; no done is issued; results clear to 0.
  - dm_rst is high during rst, so divmod also returns to ready.
- Unused or X inputs from the non-owner never reach dm_a/dm_b.

Test Plan:
- Single transfer: req0, a0=100, b0=7 -> dm_go at cycle 1; done0 pulses once; div0=14, mod0=2, err0=0; done1 stays 0.
- Simultaneous requests: req0 (a0=10, b0=3) and req1 (a1=20, b1=6) in the same cycle -> done0 first with div0=3, mod0=1; then done1 with div1=3, mod1=2; dm_go pulses exactly twice.
- Divide-by-zero: req1, a1=55, b1=0 -> done1 at cycle 3; err1=1, div1=0, mod1=0; timeout=0; a following req1 (a1=9, b1=2) gives div1=4, mod1=1, err1=0.
- Fairness: req0 and req1 held high, each re-requesting right after its done, for 6 transactions -> grant order 0,1,0,1,0,1; no done pulse is longer than 1 cycle.
- Watchdog: TIMEOUT=8, divmod stub holding dm_ready=0 -> after 8 WAIT cycles, dm_rst pulses 1 cycle; owner sees done with err=1 and timeout=1; busy returns to 0.
- Reset mid-WAIT: assert rst during a 16-bit 65535/1 division -> no done pulse; div*/mod*/err* read 0; dm_rst high during rst; the next request 81/9 returns div=9, mod=0.
